tdm_demux_1_to_4: RTL and testbench
===================================

Name: tdm_demux_1_to_4

Overview:
- Receive end of the 4-to-1 time-division link: takes a serial bitstream built by rotating a 4-to-1 mux select through slots 0..3, plus a slot-0 sync marker.
- Rebuilds the 4-bit word, slot 0 into bit 0, and presents it on a registered parallel output with a one-cycle frame strobe.
- Sits between a board input pin (or an on-chip mux) and user logic on the Elbert V2 Spartan-3 design.

Parameters:
- SLOT_CYCLES, 1, clock cycles per slot (≥1); din is sampled on the first cycle of each slot.
- PCNT_W, 4, prescaler counter width; must satisfy 2^PCNT_W ≥ SLOT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable; low freezes all state
- din  in  1  serial TDM data
- sync  in  1  high on the first cycle of slot 0
- y  out  4  last complete frame, y[k] = slot-k bit
- frame_valid  out  1  one-cycle pulse when y updates
- slot  out  2  slot index of the current cycle
- locked  out  1  high while in RUN
- sync_err  out  1  one-cycle pulse on sync violation

Behaviour:
- Reset (rst_n low, asynchronous): state = HUNT, pcnt = 0, slot = 0, shadow = 0, y = 4'b0000, frame_valid = 0, sync_err = 0, locked = 0.
- en = 0: state, pcnt, slot, shadow and y hold; frame_valid and sync_err are 0 that cycle. Takes priority over everything except reset.
- A "sample cycle" is a cycle with en = 1 and pcnt == 0.
- HUNT, en = 1, sync = 0: no change.
- HUNT, en = 1, sync = 1:
  - shadow[0] <= din; state <= RUN.
  - If SLOT_CYCLES = 1: slot <= 1, pcnt <= 0. Otherwise: slot <= 0, pcnt <= 1.
- RUN, every en cycle:
  - If pcnt == SLOT_CYCLES-1: pcnt <= 0, slot <= slot+1 (wraps 3→0). Otherwise pcnt <= pcnt+1.
- RUN, sample cycle: shadow[slot] <= din.
- RUN, sample cycle with slot == 3:
  - y <= {din, shadow[2:0]}.
  - frame_valid = 1 in the following cycle, so the pulse is coincident with the new y.
  - Latency from the slot-3 sample edge to y/frame_valid visible: 1 clock.
- RUN, sync = 1 with (slot, pcnt) ≠ (0, 0):
  - sync_err pulses the next cycle.
  - Realign: shadow[0] <= din; slot and pcnt load as on HUNT entry.
  - The partial frame is discarded: no frame_valid, y unchanged.
  - Stays in RUN.
- RUN, sync = 1 at (0, 0): normal slot-0 sample, no error.
- RUN, sync = 0 at (0, 0): accepted as free-running (see Optional Feature).
- locked = 1 exactly while state == RUN.
- slot output = internal slot register. In HUNT it reads 0.
- Reset asserted mid-frame: immediate return to reset values. No frame_valid for the partial frame.
- Shadow bits not overwritten before a realign keep stale values. They are never exposed, because y only loads on a completed slot-3 sample.

Optional Feature:
- Macro TDM_STRICT_SYNC_EN.
- Defined: every slot-0 sample cycle in RUN must have sync = 1. If sync = 0 there:
  - sync_err pulses next cycle.
  - State returns to HUNT; pcnt = 0, slot = 0, locked drops next cycle.
  - That cycle's din is discarded and y holds.
- Undefined: a missing sync at slot 0 is ignored and the demux free-runs on its slot counter.

Test Plan:
- Reset: hold rst_n = 0 for 100 ns, then release -> y = 0000, frame_valid = 0, locked = 0, slot = 0, sync_err = 0.
- Lock and frame, SLOT_CYCLES = 1: sync = 1 with din = 0 (slot 0), then din = 1, 1, 0 -> locked = 1 after the first edge; after the 4th edge y = 0110 with frame_valid = 1 for exactly 1 cycle. Next frame 1,0,0,0 with sync on its first bit -> y = 0001.
- SLOT_CYCLES = 3: frame 0010 with each bit held 3 cycles -> din sampled only at pcnt = 0; y = 0010 one clock after the 10th clock of the frame (slot-3 sample edge); slot changes every 3 cycles.
- en gating: drop en for 5 cycles mid-frame (after slot 1), then resume -> slot/pcnt frozen during the gap, no frame_valid; resulting y equals the frame with the gap removed, e.g. 0101.
- Misplaced sync: after slots 0 and 1 of a frame, assert sync with din = 1 -> sync_err pulses 1 cycle; realign so the next 3 bits 1,0,0 complete y = 0011 (sync bit = bit 0), with no frame_valid for the aborted frame.
- With TDM_STRICT_SYNC_EN: omit sync at the second frame's slot 0 -> sync_err = 1, locked = 0 next cycle, y keeps the previous frame; a later sync relocks.

Source files
------------

// File: rtl/tdm_demux_1_to_4.sv
// Receive side of a 4-slot TDM link: rebuilds the 4-bit word from a serial stream plus slot-0 sync.
// Optional macro TDM_STRICT_SYNC_EN: a missing sync at any slot-0 sample drops back to HUNT.
module tdm_demux_1_to_4 #(
    parameter int SLOT_CYCLES = 1,
    parameter int PCNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic [3:0] y,
    output logic       frame_valid,
    output logic [1:0] slot,
    output logic       locked,
    output logic       sync_err
);

    localparam logic HUNT = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SLOT_CYCLES - 1);

    // A sync edge consumes the first cycle of slot 0, so the counters resume one cycle in.
    localparam logic [1:0]        ENTRY_SLOT = (SLOT_CYCLES == 1) ? 2'd1 : 2'd0;
    localparam logic [PCNT_W-1:0] ENTRY_PCNT = (SLOT_CYCLES == 1) ? '0 : PCNT_W'(1);

    logic              state;
    logic [PCNT_W-1:0] pcnt;
    logic [2:0]        shadow;
    logic              frame_start;

    assign locked      = (state == RUN);
    assign frame_start = (slot == 2'd0) && (pcnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            pcnt        <= '0;
            slot        <= 2'd0;
            shadow      <= 3'b000;
            y           <= 4'b0000;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (en) begin
                if (state == HUNT) begin
                    if (sync) begin
                        shadow[0] <= din;
                        state     <= RUN;
                        slot      <= ENTRY_SLOT;
                        pcnt      <= ENTRY_PCNT;
                    end
                end else if (sync && !frame_start) begin
                    sync_err  <= 1'b1;
                    shadow[0] <= din;
                    slot      <= ENTRY_SLOT;
                    pcnt      <= ENTRY_PCNT;
`ifdef TDM_STRICT_SYNC_EN
                end else if (!sync && frame_start) begin
                    sync_err <= 1'b1;
                    state    <= HUNT;
                    slot     <= 2'd0;
                    pcnt     <= '0;
`endif
                end else begin
                    if (pcnt == PCNT_LAST) begin
                        pcnt <= '0;
                        slot <= slot + 2'd1;
                    end else begin
                        pcnt <= pcnt + PCNT_W'(1);
                    end
                    // Slot 3 is never shadowed: its bit goes straight into the output word.
                    if (pcnt == '0) begin
                        case (slot)
                            2'd0: shadow[0] <= din;
                            2'd1: shadow[1] <= din;
                            2'd2: shadow[2] <= din;
                            2'd3: begin
                                y           <= {din, shadow};
                                frame_valid <= 1'b1;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Bench for tdm_demux_1_to_4: two instances (1 and 3 cycles per slot) against a position-based model.
// Honours TDM_STRICT_SYNC_EN in both the model and the directed checks.
module tb_tdm_demux_1_to_4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic din = 1'b0;
    logic sync = 1'b0;

    logic [3:0] y0, y1;
    logic       fv0, fv1, lk0, lk1, err0, err1;
    logic [1:0] slot0, slot1;

    int checks = 0;
    int failures = 0;

    tdm_demux_1_to_4 #(.SLOT_CYCLES(1), .PCNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sync(sync),
        .y(y0), .frame_valid(fv0), .slot(slot0), .locked(lk0), .sync_err(err0)
    );

    tdm_demux_1_to_4 #(.SLOT_CYCLES(3), .PCNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sync(sync),
        .y(y1), .frame_valid(fv1), .slot(slot1), .locked(lk1), .sync_err(err1)
    );

    always #5 clk = ~clk;

    // Model: one position counter per instance counts enabled cycles since frame start;
    // slot = pos / SC mod 4, and a sample happens whenever pos is a multiple of SC.
    int         sc_of [2] = '{1, 3};
    int         m_pos [2] = '{0, 0};
    bit         m_lock[2] = '{0, 0};
    logic [3:0] m_bits[2] = '{4'd0, 4'd0};
    logic [3:0] m_y   [2] = '{4'd0, 4'd0};
    bit         m_fv  [2] = '{0, 0};
    bit         m_err [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        int sc;
        int s;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_pos[d] = 0; m_lock[d] = 0; m_bits[d] = 4'd0;
                m_y[d] = 4'd0; m_fv[d] = 0; m_err[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                sc = sc_of[d];
                m_fv[d] = 0;
                m_err[d] = 0;
                if (en) begin
                    if (!m_lock[d]) begin
                        if (sync) begin
                            m_bits[d][0] = din;
                            m_lock[d] = 1;
                            m_pos[d] = 1 % (4 * sc);
                        end
                    end else if (sync && m_pos[d] != 0) begin
                        m_err[d] = 1;
                        m_bits[d][0] = din;
                        m_pos[d] = 1 % (4 * sc);
`ifdef TDM_STRICT_SYNC_EN
                    end else if (!sync && m_pos[d] == 0) begin
                        m_err[d] = 1;
                        m_lock[d] = 0;
                        m_pos[d] = 0;
`endif
                    end else begin
                        s = (m_pos[d] / sc) % 4;
                        if (m_pos[d] % sc == 0) begin
                            if (s == 3) begin
                                m_y[d] = {din, m_bits[d][2], m_bits[d][1], m_bits[d][0]};
                                m_fv[d] = 1;
                            end else begin
                                m_bits[d][s] = din;
                            end
                        end
                        m_pos[d] = (m_pos[d] + 1) % (4 * sc);
                    end
                end
            end
        end
    end

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_slot(input int d);
        return m_lock[d] ? (m_pos[d] / sc_of[d]) % 4 : 0;
    endfunction

    task automatic checkOutput();
        compare("y0", int'(y0), int'(m_y[0]));
        compare("frame_valid0", int'(fv0), int'(m_fv[0]));
        compare("slot0", int'(slot0), exp_slot(0));
        compare("locked0", int'(lk0), int'(m_lock[0]));
        compare("sync_err0", int'(err0), int'(m_err[0]));
        compare("y1", int'(y1), int'(m_y[1]));
        compare("frame_valid1", int'(fv1), int'(m_fv[1]));
        compare("slot1", int'(slot1), exp_slot(1));
        compare("locked1", int'(lk1), int'(m_lock[1]));
        compare("sync_err1", int'(err1), int'(m_err[1]));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare on the falling edge.
    task automatic applyStimulus(input logic e, input logic d, input logic s);
        en = e;
        din = d;
        sync = s;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        en = 1'b0; din = 1'b0; sync = 1'b0;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
        compare("reset_y", int'(y0), 0);
        compare("reset_locked", int'(lk0), 0);
        compare("reset_slot", int'(slot0), 0);
        compare("reset_fv", int'(fv0), 0);
        compare("reset_err", int'(err0), 0);
    endtask

    initial begin
        doReset();

        // Lock and two frames at one cycle per slot.
        applyStimulus(1, 0, 1);
        compare("lock_locked", int'(lk0), 1);
        compare("lock_slot", int'(slot0), 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        compare("frameA_y", int'(y0), 4'b0110);
        compare("frameA_fv", int'(fv0), 1);
        applyStimulus(1, 1, 1);
        compare("frameA_fv_pulse", int'(fv0), 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        compare("frameB_y", int'(y0), 4'b0001);
        compare("frameB_fv", int'(fv0), 1);
        applyStimulus(1, 1, 0);
`ifdef TDM_STRICT_SYNC_EN
        compare("strict_err", int'(err0), 1);
        compare("strict_unlock", int'(lk0), 0);
`else
        compare("freerun_err", int'(err0), 0);
        compare("freerun_locked", int'(lk0), 1);
`endif
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
`ifdef TDM_STRICT_SYNC_EN
        compare("strict_y_hold", int'(y0), 4'b0001);
`else
        compare("freerun_y", int'(y0), 4'b1111);
`endif

        // Enable gap after slot 1.
        doReset();
        applyStimulus(1, 1, 1);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 0);
            compare("gap_slot", int'(slot0), 2);
            compare("gap_fv", int'(fv0), 0);
        end
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        compare("gap_y", int'(y0), 4'b0101);
        compare("gap_fv_end", int'(fv0), 1);

        // Misplaced sync realigns onto the new slot 0.
        doReset();
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 1);
        compare("missync_err", int'(err0), 1);
        compare("missync_fv", int'(fv0), 0);
        compare("missync_y", int'(y0), 0);
        applyStimulus(1, 1, 0);
        compare("missync_err_pulse", int'(err0), 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        compare("realign_y", int'(y0), 4'b0011);

        // Three cycles per slot: frame 0010.
        doReset();
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        compare("sc3_slot", int'(slot1), 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        compare("sc3_fv_early", int'(fv1), 0);
        applyStimulus(1, 0, 0);
        compare("sc3_y", int'(y1), 4'b0010);
        compare("sc3_fv", int'(fv1), 1);

        // Random traffic with occasional asynchronous mid-frame resets.
        doReset();
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                compare("async_reset_y", int'(y0), 0);
                compare("async_reset_locked", int'(lk1), 0);
                compare("async_reset_slot", int'(slot0), 0);
                @(negedge clk);
                checkOutput();
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
